// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Four-entry general register file for the 8-bit CPU datapath.
//                R0..R2 are general purpose; R3 doubles as the stack pointer
//                and resets to the top of the address space. Two
//                combinational read ports feed the operand path, and one
//                synchronous write port takes writeback results.
//
//  Ports       : clk         - system clock, writes on the rising edge
//                rst         - asynchronous active-high reset
//                wenabel     - write enable
//                ra, rb      - read-port A / B register select
//                rd          - write destination register select
//                write_data  - data written to register rd
//                ra_date     - contents of register[ra] (combinational)
//                rb_date     - contents of register[rb] (combinational)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wenabel,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] ra_date,
    output logic [DATA_W-1:0] rb_date
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Register storage and its next-state image.
    logic [DATA_W-1:0] regs_q [c_DEPTH];
    logic [DATA_W-1:0] regs_d [c_DEPTH];

    // One-hot write select, decoded from rd and gated by the enable.
    logic [c_DEPTH-1:0] w_wsel;

    generate
        for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_wsel
            assign w_wsel[gi] = wenabel && (rd == ADDR_W'(gi));
        end
    endgenerate

    // Only the addressed register takes new data; every other entry holds.
    always_comb begin
        for (int i = 0; i < c_DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (w_wsel[i]) begin
                regs_d[i] = write_data;
            end
        end
    end

    // Reset dominates any concurrent write. The highest-index register is the
    // stack pointer and comes out of reset pointing at the top of memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH - 1; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[c_DEPTH-1] <= SP_RESET;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads come straight from storage: no write-through bypass, so a read of
    // the register being written shows the old value until the edge.
    assign ra_date = regs_q[ra];
    assign rb_date = regs_q[rb];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Directed self-checking bench for register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_file;

    logic       clk;
    logic       rst;
    logic       wenabel;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rd;
    logic [7:0] write_data;
    logic [7:0] ra_date;
    logic [7:0] rb_date;

    int n_checks;
    int n_fail;

    register_file #(
        .DATA_W   (8),
        .ADDR_W   (2),
        .SP_RESET (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wenabel    (wenabel),
        .ra         (ra),
        .rb         (rb),
        .rd         (rd),
        .write_data (write_data),
        .ra_date    (ra_date),
        .rb_date    (rb_date)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle write: drive at the falling edge, sample 1 ns after the rise.
    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        rd         = a;
        write_data = d;
        wenabel    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        wenabel    = 1'b0;
    endtask

    task automatic test_reset();
        ra = 2'd0; rb = 2'd1;
        #1;
        n_checks++;
        if (ra_date !== 8'h00) begin n_fail++; $display("FAIL rst_r0: got %h expected %h", ra_date, 8'h00); end
        n_checks++;
        if (rb_date !== 8'h00) begin n_fail++; $display("FAIL rst_r1: got %h expected %h", rb_date, 8'h00); end
        ra = 2'd2; rb = 2'd3;
        #1;
        n_checks++;
        if (ra_date !== 8'h00) begin n_fail++; $display("FAIL rst_r2: got %h expected %h", ra_date, 8'h00); end
        n_checks++;
        if (rb_date !== 8'hFF) begin n_fail++; $display("FAIL rst_sp: got %h expected %h", rb_date, 8'hFF); end
        // A clock edge with a write pending must not disturb reset values.
        rd = 2'd0; write_data = 8'h33; wenabel = 1'b1; ra = 2'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ra_date !== 8'h00) begin n_fail++; $display("FAIL rst_write_ignored: got %h expected %h", ra_date, 8'h00); end
        @(negedge clk);
        wenabel = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_basic_write();
        do_write(2'd0, 8'hAA);
        ra = 2'd0; rb = 2'd1;
        #1;
        n_checks++;
        if (ra_date !== 8'hAA) begin n_fail++; $display("FAIL wr_r0: got %h expected %h", ra_date, 8'hAA); end
        n_checks++;
        if (rb_date !== 8'h00) begin n_fail++; $display("FAIL wr_r1_hold: got %h expected %h", rb_date, 8'h00); end
        do_write(2'd2, 8'h55);
        ra = 2'd2; rb = 2'd3;
        #1;
        n_checks++;
        if (ra_date !== 8'h55) begin n_fail++; $display("FAIL wr_r2: got %h expected %h", ra_date, 8'h55); end
        n_checks++;
        if (rb_date !== 8'hFF) begin n_fail++; $display("FAIL wr_sp_hold: got %h expected %h", rb_date, 8'hFF); end
    endtask

    task automatic test_overwrite();
        do_write(2'd0, 8'h0F);
        ra = 2'd0; rb = 2'd2;
        #1;
        n_checks++;
        if (ra_date !== 8'h0F) begin n_fail++; $display("FAIL ovw_r0: got %h expected %h", ra_date, 8'h0F); end
        n_checks++;
        if (rb_date !== 8'h55) begin n_fail++; $display("FAIL ovw_r2_hold: got %h expected %h", rb_date, 8'h55); end
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        rd = 2'd1; write_data = 8'h99; wenabel = 1'b0;
        @(posedge clk);
        #1;
        ra = 2'd1; rb = 2'd0;
        #1;
        n_checks++;
        if (ra_date !== 8'h00) begin n_fail++; $display("FAIL wdis_r1: got %h expected %h", ra_date, 8'h00); end
        n_checks++;
        if (rb_date !== 8'h0F) begin n_fail++; $display("FAIL wdis_r0_hold: got %h expected %h", rb_date, 8'h0F); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;                 // 3 ns before the next rising edge
        ra = 2'd0; rb = 2'd2;
        #1;
        n_checks++;
        if (ra_date !== 8'h00) begin n_fail++; $display("FAIL arst_r0: got %h expected %h", ra_date, 8'h00); end
        n_checks++;
        if (rb_date !== 8'h00) begin n_fail++; $display("FAIL arst_r2: got %h expected %h", rb_date, 8'h00); end
        rb = 2'd3;
        #0.5;
        n_checks++;
        if (rb_date !== 8'hFF) begin n_fail++; $display("FAIL arst_sp: got %h expected %h", rb_date, 8'hFF); end
        rd = 2'd1; write_data = 8'h77; wenabel = 1'b1; ra = 2'd1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ra_date !== 8'h00) begin n_fail++; $display("FAIL arst_write_ignored: got %h expected %h", ra_date, 8'h00); end
        // Release reset with the write still requested: the first edge after
        // release must perform it.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ra_date !== 8'h77) begin n_fail++; $display("FAIL release_first_write: got %h expected %h", ra_date, 8'h77); end
        @(negedge clk);
        wenabel = 1'b0;
    endtask

    task automatic test_sp_rdw();
        @(negedge clk);
        ra = 2'd3; rb = 2'd3; rd = 2'd3; write_data = 8'hFE; wenabel = 1'b1;
        #1;
        n_checks++;
        if (ra_date !== 8'hFF) begin n_fail++; $display("FAIL rdw_before_a: got %h expected %h", ra_date, 8'hFF); end
        n_checks++;
        if (rb_date !== 8'hFF) begin n_fail++; $display("FAIL rdw_before_b: got %h expected %h", rb_date, 8'hFF); end
        @(posedge clk);
        #1;
        n_checks++;
        if (ra_date !== 8'hFE) begin n_fail++; $display("FAIL rdw_after_a: got %h expected %h", ra_date, 8'hFE); end
        n_checks++;
        if (rb_date !== 8'hFE) begin n_fail++; $display("FAIL rdw_after_b: got %h expected %h", rb_date, 8'hFE); end
        @(negedge clk);
        wenabel = 1'b0;
        ra = 2'd1; rb = 2'd0;
        #1;
        n_checks++;
        if (ra_date !== 8'h77) begin n_fail++; $display("FAIL sp_iso_r1: got %h expected %h", ra_date, 8'h77); end
        n_checks++;
        if (rb_date !== 8'h00) begin n_fail++; $display("FAIL sp_iso_r0: got %h expected %h", rb_date, 8'h00); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        wenabel    = 1'b0;
        ra         = 2'd0;
        rb         = 2'd0;
        rd         = 2'd0;
        write_data = 8'h00;

        test_reset();
        test_basic_write();
        test_overwrite();
        test_write_disabled();
        test_async_reset();
        test_sp_rdw();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
